// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared types and arithmetic helpers for the ES1 SPU op blocks.
package elixirchip_es1_spu_pkg;

  // Fold operation selected by the OP string parameter.
  typedef enum logic [1:0] {
    SPU_OP_ADD = 2'd0,
    SPU_OP_SUB = 2'd1,
    SPU_OP_MAX = 2'd2,
    SPU_OP_MIN = 2'd3
  } spu_op_e;

  // Widest data path the helpers support; one spare bit is kept for the carry.
  localparam int SPU_MAX_BITS = 64;

  typedef logic [SPU_MAX_BITS-1:0] spu_word_t;

  // Result of a saturating add/sub: the overflow strobe plus the final value.
  typedef struct packed {
    logic      ovf;
    spu_word_t value;
  } spu_arith_t;

  // Low 'bits' bits set.
  function automatic spu_word_t spu_mask(input int unsigned bits);
    return (spu_word_t'(1) << bits) - spu_word_t'(1);
  endfunction

  // Only the sign bit of a 'bits'-wide word set.
  function automatic spu_word_t spu_msb(input int unsigned bits);
    return spu_word_t'(1) << (bits - 1);
  endfunction

  // Largest positive two's-complement value, 0x7F..F.
  function automatic spu_word_t spu_smax(input int unsigned bits);
    return spu_msb(bits) - spu_word_t'(1);
  endfunction

  // Most negative two's-complement value, 0x80..0.
  function automatic spu_word_t spu_smin(input int unsigned bits);
    return spu_msb(bits);
  endfunction

  // Add or subtract (a - b) two 'bits'-wide words, flag overflow, and clamp
  // the result when saturate is set; otherwise the low bits wrap.
  function automatic spu_arith_t spu_addsub(
    input spu_word_t   a_in,
    input spu_word_t   b_in,
    input int unsigned bits,
    input logic        is_signed,
    input logic        is_sub,
    input logic        saturate
  );
    spu_word_t  mask;
    spu_word_t  msb;
    spu_word_t  a;
    spu_word_t  b;
    spu_word_t  sum;
    spu_word_t  res;
    logic       carry;
    logic       sa;
    logic       sb;
    logic       sr;
    logic       ovf;
    spu_arith_t ret;
    mask  = spu_mask(bits);
    msb   = spu_msb(bits);
    a     = a_in & mask;
    b     = b_in & mask;
    sum   = is_sub ? (a - b) : (a + b);
    res   = sum & mask;
    // Operands are below 2^bits, so any bit above the mask is the carry.
    carry = is_sub ? (a < b) : (|(sum & ~mask));
    sa    = |(a & msb);
    sb    = |(b & msb);
    sr    = |(res & msb);
    if (is_signed) begin
      ovf = is_sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    end else begin
      ovf = carry;
    end
    if (ovf && saturate) begin
      // Signed overflow always runs in the direction of the first operand's sign.
      if (is_signed) res = sa ? spu_smin(bits) : spu_smax(bits);
      else           res = is_sub ? '0 : mask;
    end
    ret.ovf   = ovf;
    ret.value = res;
    return ret;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_delay.sv
// cke-gated shift register with asynchronous reset; DEPTH 0 is a plain wire.
module elixirchip_es1_spu_delay #(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cke,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH <= 0) begin : g_wire
    logic w_unused_ctl;
    assign w_unused_ctl = clk ^ reset ^ cke;
    assign o_data       = i_data;
  end else begin : g_shift
    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift one stage per enabled clock; everything holds while cke is low.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VALUE;
      end else if (cke) begin
        r_stage[0] <= i_data;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_data = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/elixirchip_es1_spu_op_acc.sv
// Accumulator SPU stage: folds valid samples into one register with
// add/sub/max/min, optional saturation, sticky overflow and a sample count.
// Stage 1 is the accumulator; stages 2..LATENCY are plain delay registers.
module elixirchip_es1_spu_op_acc
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int    LATENCY    = 1,
  parameter int    DATA_BITS  = 8,
  parameter type   data_t     = logic [DATA_BITS-1:0],
  parameter bit    SIGNED     = 1'b0,
  parameter bit    SATURATE   = 1'b1,
  parameter string OP         = "ADD",
  parameter data_t CLEAR_DATA = '0,
  parameter int    COUNT_BITS = 16,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cke,
  input  data_t                 s_data,
  input  logic                  s_clear,
  input  logic                  s_valid,
  output data_t                 m_data,
  output logic                  m_valid,
  output logic                  m_overflow,
  output logic [COUNT_BITS-1:0] m_count
);

  localparam bit OP_VALID = (OP == "ADD") || (OP == "SUB") || (OP == "MAX") || (OP == "MIN");
  localparam spu_op_e OP_SEL = (OP == "SUB") ? SPU_OP_SUB :
                               (OP == "MAX") ? SPU_OP_MAX :
                               (OP == "MIN") ? SPU_OP_MIN : SPU_OP_ADD;
  localparam int BUNDLE_BITS = DATA_BITS + 2 + COUNT_BITS;
  localparam logic [BUNDLE_BITS-1:0] BUNDLE_RESET = {CLEAR_DATA, 1'b0, 1'b0, {COUNT_BITS{1'b0}}};

  // Elaboration-time parameter checks.
  if (!OP_VALID) begin : g_bad_op
    $error("elixirchip_es1_spu_op_acc: OP must be ADD, SUB, MAX or MIN");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("elixirchip_es1_spu_op_acc: LATENCY must be >= 1");
  end
  if (DATA_BITS < 1 || DATA_BITS >= SPU_MAX_BITS) begin : g_bad_width
    $error("elixirchip_es1_spu_op_acc: DATA_BITS out of range");
  end
  if (COUNT_BITS < 1) begin : g_bad_count
    $error("elixirchip_es1_spu_op_acc: COUNT_BITS must be >= 1");
  end
  if (DEVICE == "") begin : g_bad_device
    $error("elixirchip_es1_spu_op_acc: DEVICE must be named");
  end
  if (SIMULATION != "true" && SIMULATION != "false") begin : g_bad_sim
    $error("elixirchip_es1_spu_op_acc: SIMULATION must be true or false");
  end
  if (DEBUG != "true" && DEBUG != "false") begin : g_bad_debug
    $error("elixirchip_es1_spu_op_acc: DEBUG must be true or false");
  end

  logic [DATA_BITS-1:0]   w_s_data;
  logic [DATA_BITS-1:0]   r_acc;
  logic                   r_ovf;
  logic [COUNT_BITS-1:0]  r_cnt;
  logic                   r_valid;
  spu_arith_t             w_addsub;
  logic                   w_unused_hi;
  logic                   w_s_gt;
  logic                   w_s_lt;
  logic [DATA_BITS-1:0]   w_fold;
  logic                   w_fold_ovf;
  logic [BUNDLE_BITS-1:0] w_stage1;
  logic [BUNDLE_BITS-1:0] w_out;

  assign w_s_data = s_data;

  // Arithmetic fold and signedness-aware compares against the current accumulator.
  always_comb begin
    w_addsub = spu_addsub(spu_word_t'(r_acc), spu_word_t'(w_s_data), DATA_BITS,
                          SIGNED, (OP_SEL == SPU_OP_SUB), SATURATE);
    if (SIGNED) begin
      w_s_gt = $signed(w_s_data) > $signed(r_acc);
      w_s_lt = $signed(w_s_data) < $signed(r_acc);
    end else begin
      w_s_gt = w_s_data > r_acc;
      w_s_lt = w_s_data < r_acc;
    end
  end

  assign w_unused_hi = |w_addsub.value[SPU_MAX_BITS-1:DATA_BITS];

  // Select the folded value for the configured operation; max/min never overflow.
  always_comb begin
    w_fold     = r_acc;
    w_fold_ovf = 1'b0;
    case (OP_SEL)
      SPU_OP_ADD, SPU_OP_SUB: begin
        w_fold     = w_addsub.value[DATA_BITS-1:0];
        w_fold_ovf = w_addsub.ovf;
      end
      SPU_OP_MAX: w_fold = w_s_gt ? w_s_data : r_acc;
      SPU_OP_MIN: w_fold = w_s_lt ? w_s_data : r_acc;
      default:    w_fold = r_acc;
    endcase
  end

  // Stage 1: accumulator, sticky overflow and saturating sample counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc   <= CLEAR_DATA;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (cke) begin
      r_valid <= s_valid;
      if (s_clear && s_valid) begin
        r_acc <= w_s_data;
        r_ovf <= 1'b0;
        r_cnt <= COUNT_BITS'(1);
      end else if (s_clear) begin
        r_acc <= CLEAR_DATA;
        r_ovf <= 1'b0;
        r_cnt <= '0;
      end else if (s_valid) begin
        r_acc <= w_fold;
        r_ovf <= r_ovf | w_fold_ovf;
        if (r_cnt != {COUNT_BITS{1'b1}}) r_cnt <= r_cnt + COUNT_BITS'(1);
      end
    end
  end

  assign w_stage1 = {r_acc, r_valid, r_ovf, r_cnt};

  elixirchip_es1_spu_delay #(
    .WIDTH       (BUNDLE_BITS),
    .DEPTH       (LATENCY - 1),
    .RESET_VALUE (BUNDLE_RESET)
  ) u_delay (
    .clk    (clk),
    .reset  (reset),
    .cke    (cke),
    .i_data (w_stage1),
    .o_data (w_out)
  );

  assign {m_data, m_valid, m_overflow, m_count} = w_out;

endmodule
